// File: rtl/median_frame_sequencer_if.sv
// median_frame_sequencer_if
//   Bundles every stream and filter-side signal of the frame sequencer.
//
//   Handshake rule for both pixel streams (pix_in_*, pix_out_*): a beat
//   transfers on a rising clk edge where valid and ready are both high.
//   A source holds its data and valid stable until that edge. Ready may be
//   raised or lowered at any time and never depends on valid.
//
//   The MEDIAN side is not a valid/ready pair. med_dsi marks each of the
//   nine window beats on med_di. med_dso marks a result on med_do.
//
//   Signals
//     pix_in / pix_in_valid / pix_in_ready     input pixel stream
//     med_di / med_dsi                         window beats to MEDIAN
//     med_do / med_dso                         result from MEDIAN
//     pix_out / pix_out_valid / pix_out_ready  filtered pixel stream
//     frame_done                               last output pixel accepted
//
//   Modports
//     slave  : the sequencer itself
//     master : its surroundings (source, sink and MEDIAN)

interface median_frame_sequencer_if;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic       pix_in_ready;
  logic [7:0] med_di;
  logic       med_dsi;
  logic [7:0] med_do;
  logic       med_dso;
  logic [7:0] pix_out;
  logic       pix_out_valid;
  logic       pix_out_ready;
  logic       frame_done;

  modport slave (
    input  pix_in, pix_in_valid, med_do, med_dso, pix_out_ready,
    output pix_in_ready, med_di, med_dsi, pix_out, pix_out_valid, frame_done
  );

  modport master (
    output pix_in, pix_in_valid, med_do, med_dso, pix_out_ready,
    input  pix_in_ready, med_di, med_dsi, pix_out, pix_out_valid, frame_done
  );
endinterface

// File: rtl/median_frame_sequencer.sv
// median_frame_sequencer
//   Buffers one W x H greyscale frame, then walks every interior pixel in
//   raster order. For each pixel it does three things:
//     - streams the 3x3 neighbourhood into an external MEDIAN unit,
//       row-major from the top-left corner
//     - waits for a fresh result
//     - presents that result on the output stream
//   Border pixels produce no output. A frame therefore yields
//   (W-2)*(H-2) pixels.
//
//   Ports
//     clk        rising-edge clock
//     nrst       asynchronous active-low reset
//     bus        median_frame_sequencer_if.slave (streams and MEDIAN link)
//     state_dbg  current FSM state, for observation only
//
//   Parameters
//     W, H       frame width and height in pixels (each >= 3)

module median_frame_sequencer #(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  median_frame_sequencer_if.slave   bus,
  output logic [1:0]                state_dbg
);

  localparam int NPIX = W * H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
  localparam logic [AW-1:0] X_LAST   = AW'(W - 2);
  localparam logic [AW-1:0] Y_LAST   = AW'(H - 2);
  localparam logic [AW-1:0] W_C      = AW'(W);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FEED = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] in_cnt;
  logic [AW-1:0] x;
  logic [AW-1:0] y;
  // Window beat index k is kept as row (kr = k/3) and column (kc = k%3).
  // The address then needs no divider.
  logic [1:0]    kr;
  logic [1:0]    kc;
  logic          arm;

  logic [7:0]    med_di_q;
  logic          med_dsi_q;
  logic [7:0]    pix_out_q;
  logic          pix_out_valid_q;
  logic          frame_done_q;

  logic [7:0]    mem [NPIX];

  logic [AW-1:0] row_idx;
  logic [AW-1:0] col_idx;
  logic [AW-1:0] rd_addr;

  // Neighbourhood address. x and y are always interior, so x-1+kc and
  // y-1+kr never underflow.
  always_comb begin
    row_idx = y + AW'(kr) - AW'(1);
    col_idx = x + AW'(kc) - AW'(1);
    rd_addr = row_idx * W_C + col_idx;
  end

  // Frame store. It has no reset: a new frame always overwrites every
  // location before FEED reads any of them.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && bus.pix_in_valid) begin
      mem[in_cnt] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= ST_LOAD;
      in_cnt          <= '0;
      x               <= '0;
      y               <= '0;
      kr              <= '0;
      kc              <= '0;
      arm             <= 1'b0;
      med_di_q        <= '0;
      med_dsi_q       <= 1'b0;
      pix_out_q       <= '0;
      pix_out_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      med_dsi_q    <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (bus.pix_in_valid) begin
            if (in_cnt == LAST_IDX) begin
              in_cnt <= '0;
              x      <= AW'(1);
              y      <= AW'(1);
              kr     <= '0;
              kc     <= '0;
              arm    <= 1'b0;
              state  <= ST_FEED;
            end else begin
              in_cnt <= in_cnt + AW'(1);
            end
          end
        end

        ST_FEED: begin
          med_di_q  <= mem[rd_addr];
          med_dsi_q <= 1'b1;
          // A result still showing from the previous window must not count.
          arm       <= 1'b0;
          if (kc == 2'd2) begin
            kc <= '0;
            if (kr == 2'd2) begin
              kr    <= '0;
              state <= ST_WAIT;
            end else begin
              kr <= kr + 2'd1;
            end
          end else begin
            kc <= kc + 2'd1;
          end
        end

        ST_WAIT: begin
          // Arm only after DSO has been seen low once. This guarantees
          // that the captured result belongs to the window just sent.
          if (!arm) begin
            if (!bus.med_dso) begin
              arm <= 1'b1;
            end
          end else if (bus.med_dso) begin
            pix_out_q       <= bus.med_do;
            pix_out_valid_q <= 1'b1;
            state           <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (bus.pix_out_ready) begin
            pix_out_valid_q <= 1'b0;
            if (x < X_LAST) begin
              x     <= x + AW'(1);
              state <= ST_FEED;
            end else if (y < Y_LAST) begin
              x     <= AW'(1);
              y     <= y + AW'(1);
              state <= ST_FEED;
            end else begin
              x            <= '0;
              y            <= '0;
              frame_done_q <= 1'b1;
              state        <= ST_LOAD;
            end
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

  assign bus.pix_in_ready  = (state == ST_LOAD);
  assign bus.med_di        = med_di_q;
  assign bus.med_dsi       = med_dsi_q;
  assign bus.pix_out       = pix_out_q;
  assign bus.pix_out_valid = pix_out_valid_q;
  assign bus.frame_done    = frame_done_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// tb_median_frame_sequencer
//   Drives 8x8 frames into median_frame_sequencer. A behavioural MEDIAN
//   unit with random latency is attached, in one of two modes: DSO pulses
//   for one cycle, or DSO stays high until the next result. The bench
//   compares every output pixel against medians computed directly from
//   the frame.

module tb_median_frame_sequencer;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int N    = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk  = 1'b0;
  logic       nrst = 1'b1;
  logic [1:0] state_dbg;

  median_frame_sequencer_if ifc ();

  median_frame_sequencer #(.W(W), .H(H)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (ifc),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters and data ----------------
  int checks = 0;
  int passes = 0;

  logic [7:0] frame [N];
  logic [7:0] exp_q [$];

  // ---------------- MEDIAN model ----------------
  logic [7:0] beats [$];
  logic [7:0] first_win [9];
  logic [7:0] res_val;
  int         pend_cnt   = 0;
  bit         pend       = 0;
  bit         pulse_clr  = 0;
  bit         stale_mode = 0;
  int         win_count  = 0;
  int         run_len    = 0;
  int         runs       = 0;
  int         bad_runs   = 0;

  // Reacts on the falling edge, so it samples DI/DSI mid-cycle and drives
  // DO/DSO well away from the rising edge.
  always @(negedge clk) begin
    if (!nrst) begin
      beats.delete();
      pend        = 0;
      pulse_clr   = 0;
      run_len     = 0;
      ifc.med_dso = 1'b0;
      ifc.med_do  = 8'd0;
    end else begin
      if (pulse_clr) begin
        ifc.med_dso = 1'b0;
        pulse_clr   = 0;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 1) ifc.med_dso = 1'b0;
        if (pend_cnt == 0) begin
          ifc.med_dso = 1'b1;
          ifc.med_do  = res_val;
          pend        = 0;
          if (!stale_mode) pulse_clr = 1;
        end
      end
      if (ifc.med_dsi) begin
        beats.push_back(ifc.med_di);
        run_len++;
        if (beats.size() == 9) begin
          if (win_count == 0) begin
            for (int j = 0; j < 9; j++) first_win[j] = beats[j];
          end
          beats.sort();
          res_val = beats[4];
          beats.delete();
          win_count++;
          pend     = 1;
          pend_cnt = $urandom_range(2, 5);
        end
      end else if (run_len != 0) begin
        runs++;
        if (run_len != 9) bad_runs++;
        run_len = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: median of each interior 3x3 window, in raster order.
  task automatic build_exp();
    logic [7:0] w [$];
    exp_q.delete();
    for (int yy = 1; yy < H - 1; yy++) begin
      for (int xx = 1; xx < W - 1; xx++) begin
        w.delete();
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            w.push_back(frame[(yy + dy) * W + (xx + dx)]);
        w.sort();
        exp_q.push_back(w[4]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_in_ready"},  32'(ifc.pix_in_ready),  32'd1);
    chk({tag, "_med_di"},        32'(ifc.med_di),        32'd0);
    chk({tag, "_med_dsi"},       32'(ifc.med_dsi),       32'd0);
    chk({tag, "_pix_out"},       32'(ifc.pix_out),       32'd0);
    chk({tag, "_pix_out_valid"}, 32'(ifc.pix_out_valid), 32'd0);
    chk({tag, "_frame_done"},    32'(ifc.frame_done),    32'd0);
  endtask

  task automatic load_frame();
    int t;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ifc.pix_in_valid = 1'b0;
        step();
      end
      ifc.pix_in       = frame[i];
      ifc.pix_in_valid = 1'b1;
      t = 0;
      while (!ifc.pix_in_ready && t < 50) begin
        step();
        t++;
      end
      step();
    end
    ifc.pix_in_valid = 1'b0;
  endtask

  task automatic backpressure_hold();
    logic [7:0] po;
    logic [1:0] st;
    int viol;
    ifc.pix_out_ready = 1'b0;
    po   = ifc.pix_out;
    st   = state_dbg;
    viol = 0;
    repeat (20) begin
      step();
      if (ifc.pix_out !== po || ifc.pix_out_valid !== 1'b1 || ifc.med_dsi !== 1'b0 ||
          ifc.pix_in_ready !== 1'b0 || state_dbg !== st)
        viol++;
    end
    chk("bp_hold_violations", 32'(viol), 32'd0);
    ifc.pix_out_ready = 1'b1;
    step();
    chk("bp_release_dsi_low", 32'(ifc.med_dsi), 32'd0);
    step();
    chk("bp_second_window_dsi", 32'(ifc.med_dsi), 32'd1);
  endtask

  // Runs one frame. tie_ready keeps PIX_OUT_READY high. bp_first stalls
  // the first output for 20 cycles. abort_win >= 1 resets in the middle
  // of that window's beat k=4.
  task automatic run_frame(input string name, input bit tie_ready, input bit bp_first,
                           input int abort_win);
    int  got;
    int  budget;
    bit  aborted;
    build_exp();
    win_count         = 0;
    runs              = 0;
    bad_runs          = 0;
    ifc.pix_out_ready = tie_ready;
    load_frame();
    chk({name, "_ready_low_after_load"}, 32'(ifc.pix_in_ready), 32'd0);
    step();
    chk({name, "_dsi_latency"}, 32'(ifc.med_dsi), 32'd1);
    got     = 0;
    budget  = 20000;
    aborted = 0;
    while (got < NOUT && budget > 0 && !aborted) begin
      step();
      budget--;
      if (abort_win > 0 && win_count == abort_win - 1 && beats.size() == 4) begin
        nrst = 1'b0;
        #1;
        check_reset_outputs({name, "_midfeed_reset"});
        step();
        step();
        nrst    = 1'b1;
        aborted = 1;
      end else if (ifc.pix_out_valid) begin
        chk({name, "_pix_out"}, 32'(ifc.pix_out), 32'(exp_q[0]));
        if (bp_first && got == 0) begin
          backpressure_hold();
          void'(exp_q.pop_front());
          got++;
        end else begin
          ifc.pix_out_ready = tie_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
          if (ifc.pix_out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
    end
    if (!aborted) begin
      chk({name, "_output_count"}, 32'(got), 32'(NOUT));
      step();
      chk({name, "_frame_done_pulse"}, 32'(ifc.frame_done), 32'd1);
      chk({name, "_pix_in_ready_back"}, 32'(ifc.pix_in_ready), 32'd1);
      chk({name, "_no_extra_output"}, 32'(ifc.pix_out_valid), 32'd0);
      step();
      chk({name, "_frame_done_one_cycle"}, 32'(ifc.frame_done), 32'd0);
      chk({name, "_dsi_runs"}, 32'(runs), 32'(NOUT));
      chk({name, "_dsi_bad_runs"}, 32'(bad_runs), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ifc.pix_in        = 8'd0;
    ifc.pix_in_valid  = 1'b0;
    ifc.pix_out_ready = 1'b0;

    #2 nrst = 1'b0;
    #1;
    check_reset_outputs("reset");
    step();
    step();
    nrst = 1'b1;
    step();

    // Constant frame
    stale_mode = 0;
    for (int i = 0; i < N; i++) frame[i] = 8'd50;
    run_frame("const", 1'b1, 1'b0, 0);

    // Ramp frame, plus a probe of the first window's beats
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        frame[yy * W + xx] = 8'(xx + 8 * yy);
    run_frame("ramp", 1'b1, 1'b0, 0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("ramp_first_win_k%0d", k), 32'(first_win[k]), 32'((k / 3) * W + (k % 3)));

    // Impulse noise, stale DSO, random output stalls
    stale_mode = 1;
    for (int i = 0; i < N; i++) frame[i] = 8'd10;
    frame[3 * W + 3] = 8'd255;
    frame[2 * W + 5] = 8'd0;
    run_frame("impulse", 1'b0, 1'b0, 0);

    // Random frame with a long stall at the first output
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 255));
    run_frame("backpressure", 1'b1, 1'b1, 0);

    // Reset in the middle of window 10, then a clean random frame
    stale_mode = 0;
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 255));
    run_frame("abort", 1'b1, 1'b0, 10);
    step();
    check_reset_outputs("after_abort");

    stale_mode = 1;
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 255));
    run_frame("random", 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
